// File: rtl/lsu_align_unit.sv
// lsu_align_unit
//   Load/store alignment unit sitting between the MEM-stage request port and a
//   word-organised data memory (async read, sync write with byte enables).
//   Byte/half/word requests are turned into one word access, or two when the
//   bytes straddle a word boundary. Store data is lane-shifted with matching
//   byte enables; load data is merged from the word(s) and sign/zero-extended.
//   One request at a time; a one-cycle response pulse reports completion.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_we, req_type    store flag; 000 b, 001 h, 010 w, 011 bu, 100 hu
//   req_addr, req_wdata byte address, LSB-justified store data
//   rsp_valid/rdata/err one-cycle response; rdata/err hold until next response
//   mem_*               word-index memory port, mem_rdata valid same cycle
//
// Build option
//   LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are not performed and
//   return rsp_err instead of being split.
module lsu_align_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t              state_reg;
  logic                we_reg;
  logic [2:0]          type_reg;
  logic [ADDR_W+1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         first_reg;
  logic [31:0]         rsp_rdata_reg;
  logic                rsp_err_reg;

  logic [1:0]          off;
  logic [3:0]          size_mask;
  logic [3:0]          nbytes;
  logic [3:0]          span;
  logic                illegal;
  logic                err;
  logic                split;
  logic                active;
  logic [7:0]          be_wide;
  logic [63:0]         wdata_wide;
  logic [ADDR_W-1:0]   word_idx;
  logic [63:0]         load_src;
  logic [31:0]         load_word;
  logic [31:0]         load_ext;
  logic                finish;
  logic                unused_addr_hi;

  // Address bits above the memory's reach are intentionally dropped.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign off      = addr_reg[1:0];
  assign word_idx = addr_reg[ADDR_W+1:2];

  always_comb begin
    size_mask = 4'b0000;
    nbytes    = 4'd0;
    case (type_reg)
      3'b000, 3'b011: begin size_mask = 4'b0001; nbytes = 4'd1; end
      3'b001, 3'b100: begin size_mask = 4'b0011; nbytes = 4'd2; end
      3'b010:         begin size_mask = 4'b1111; nbytes = 4'd4; end
      default:        begin size_mask = 4'b0000; nbytes = 4'd0; end
    endcase
  end

  // Unsigned load types have no store counterpart.
  assign illegal = (type_reg > 3'd4) || (we_reg && (type_reg > 3'd2));

`ifdef LSU_MISALIGN_TRAP_EN
  assign err = illegal || ((nbytes == 4'd2) && off[0]) || ((nbytes == 4'd4) && (off != 2'd0));
`else
  assign err = illegal;
`endif

  assign span  = {2'b00, off} + nbytes;
  assign split = !err && (span > 4'd4);

  // Low nibble / low word feed the first access, the spill-over feeds the second.
  assign be_wide    = {4'b0000, size_mask} << off;
  assign wdata_wide = {32'h0, wdata_reg} << {off, 3'b000};

  // Enables are gated by rst so a reset during ACC2 blocks that edge's write.
  assign active    = !rst && !err && ((state_reg == ACC1) || (state_reg == ACC2));
  assign mem_rd_en = active && !we_reg;
  assign mem_wr_en = active && we_reg;
  assign mem_addr  = !active ? '0 :
                     (state_reg == ACC2) ? word_idx + ADDR_W'(1) : word_idx;
  assign mem_be    = !active ? 4'b0000 :
                     (state_reg == ACC2) ? be_wide[7:4] : be_wide[3:0];
  assign mem_wdata = !active ? 32'h0 :
                     (state_reg == ACC2) ? wdata_wide[63:32] : wdata_wide[31:0];

  assign req_ready = (state_reg == IDLE) && !rst;
  assign rsp_valid = (state_reg == RESP) && !rst;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // In ACC2 the upper word is live on mem_rdata and the lower one was captured.
  assign load_src  = (state_reg == ACC2) ? {mem_rdata, first_reg} : {32'h0, mem_rdata};
  assign load_word = 32'(load_src >> {off, 3'b000});

  always_comb begin
    load_ext = 32'h0;
    case (type_reg)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b010:  load_ext = load_word;
      3'b011:  load_ext = {24'h0, load_word[7:0]};
      3'b100:  load_ext = {16'h0, load_word[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  assign finish = ((state_reg == ACC1) && !split) || (state_reg == ACC2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      type_reg      <= 3'b000;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      first_reg     <= 32'h0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (finish) begin
        rsp_err_reg   <= err;
        rsp_rdata_reg <= (err || we_reg) ? 32'h0 : load_ext;
      end
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            type_reg  <= req_type;
            addr_reg  <= req_addr[ADDR_W+1:0];
            wdata_reg <= req_wdata;
            state_reg <= ACC1;
          end
        end
        ACC1: begin
          first_reg <= mem_rdata;
          state_reg <= split ? ACC2 : RESP;
        end
        ACC2:    state_reg <= RESP;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Testbench for lsu_align_unit: word memory model driven by the DUT, plus a
// byte-addressed reference memory used to predict every transaction.
module tb_lsu_align_unit;

  localparam int ADDR_W = 5;
  localparam int NW     = 1 << ADDR_W;
  localparam int NB     = 4 * NW;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_type;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;

  logic [31:0] tmem [NW];
  logic [7:0]  mref [NB];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-transaction record of the memory-active cycles.
  logic [31:0] rec_addr [2];
  logic [3:0]  rec_be   [2];

  always #5 clk = ~clk;

  lsu_align_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = tmem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int l = 0; l < 4; l++)
        if (mem_be[l]) tmem[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] ty);
    if (ty == 3'd0 || ty == 3'd3) return 1;
    if (ty == 3'd1 || ty == 3'd4) return 2;
    if (ty == 3'd2) return 4;
    return 0;
  endfunction

  function automatic bit is_err(input bit we, input logic [2:0] ty, input logic [31:0] a);
    int n;
    n = size_of(ty);
    if (ty > 3'd4 || (we && ty > 3'd2)) return 1'b1;
    if (TRAP && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0))) return 1'b1;
    return 1'b0;
  endfunction

  // Runs one request from an IDLE cycle and checks it against the byte model.
  task automatic xact(input bit we, input logic [2:0] ty, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd);
    int          n, off, eacc, elat, got, nact;
    bit          err;
    logic [31:0] eaddr [2];
    logic [3:0]  ebe   [2];
    logic [31:0] ewd   [2];
    logic [31:0] raw, erd, o_rd, o_err;
    logic [31:0] acc_wd [2];
    logic        acc_we [2];
    logic        acc_re [2];

    n    = size_of(ty);
    off  = int'(a[1:0]);
    err  = is_err(we, ty, a);
    eacc = err ? 0 : ((off + n > 4) ? 2 : 1);
    elat = (eacc == 2) ? 3 : 2;
    for (int c = 0; c < 2; c++) begin
      eaddr[c] = 0; ebe[c] = 0; ewd[c] = 0;
    end
    raw = 0;
    for (int i = 0; i < n; i++) begin
      int b, c, lane;
      b    = (int'(a[6:0]) + i) % NB;
      c    = (off + i >= 4) ? 1 : 0;
      lane = (off + i) % 4;
      eaddr[c] = b / 4;
      ebe[c][lane] = 1'b1;
      ewd[c][lane*8 +: 8] = wd[i*8 +: 8];
      raw[i*8 +: 8] = mref[b];
    end
    case (ty)
      3'd0:    erd = {{24{raw[7]}}, raw[7:0]};
      3'd1:    erd = {{16{raw[15]}}, raw[15:0]};
      3'd2:    erd = raw;
      default: erd = raw;
    endcase
    if (we || err) erd = 0;

    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_type = ty; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0; nact = 0; o_rd = 0; o_err = 0;
    for (int c = 0; c < 2; c++) begin
      rec_addr[c] = 0; rec_be[c] = 0; acc_wd[c] = 0; acc_we[c] = 0; acc_re[c] = 0;
    end
    for (int k = 1; k <= 6; k++) begin
      if (mem_rd_en || mem_wr_en) begin
        if (nact < 2) begin
          rec_addr[nact] = 32'(mem_addr);
          rec_be[nact]   = mem_be;
          acc_wd[nact]   = mem_wdata;
          acc_we[nact]   = mem_wr_en;
          acc_re[nact]   = mem_rd_en;
        end
        nact++;
      end
      if (rsp_valid) begin
        got = k; o_rd = rsp_rdata; o_err = {31'h0, rsp_err};
        @(posedge clk); #1;
        chk("rsp_pulse_width", {31'h0, rsp_valid}, 32'h0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("rsp_latency", got, elat);
    chk("rsp_err", o_err, {31'h0, err});
    chk("rsp_rdata", o_rd, erd);
    chk("num_mem_cycles", nact, eacc);
    for (int c = 0; c < eacc && c < nact; c++) begin
      logic [31:0] m;
      m = {{8{ebe[c][3]}}, {8{ebe[c][2]}}, {8{ebe[c][1]}}, {8{ebe[c][0]}}};
      chk("mem_addr", rec_addr[c], eaddr[c]);
      chk("mem_be", {28'h0, rec_be[c]}, {28'h0, ebe[c]});
      chk("mem_wr_en", {31'h0, acc_we[c]}, {31'h0, we});
      chk("mem_rd_en", {31'h0, acc_re[c]}, {31'h0, !we});
      if (we) chk("mem_wdata", acc_wd[c] & m, ewd[c]);
    end
    $display("xact we=%0d type=%0d addr=0x%08h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h",
             we, ty, a, wd, got, o_err, o_rd);
    if (we && !err)
      for (int i = 0; i < n; i++) mref[(int'(a[6:0]) + i) % NB] = wd[i*8 +: 8];
    rd = o_rd;
  endtask

  initial begin
    logic [31:0] rd, v;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int w = 0; w < NW; w++) begin
      v = (w == 0) ? 32'h44332211 : (w == 1) ? 32'h88776655 : $urandom;
      tmem[w] <= v;
      for (int l = 0; l < 4; l++) mref[4*w + l] = v[l*8 +: 8];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, req_ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_mem_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
    chk("reset_mem_be", {28'h0, mem_be}, 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // Directed test-plan sequence.
    xact(1'b0, 3'd2, 32'h0, 32'h0, rd);
    chk("lw0_value", rd, 32'h44332211);
    chk("lw0_be", {28'h0, rec_be[0]}, 32'hF);
    xact(1'b0, 3'd0, 32'h7, 32'h0, rd);
    chk("lb7_value", rd, 32'hFFFFFF88);
    xact(1'b0, 3'd3, 32'h7, 32'h0, rd);
    chk("lbu7_value", rd, 32'h00000088);
    xact(1'b0, 3'd1, 32'h0, 32'h0, rd);
    chk("lh0_value", rd, 32'h00002211);
    xact(1'b0, 3'd4, 32'h6, 32'h0, rd);
    chk("lhu6_value", rd, 32'h00008877);
    xact(1'b0, 3'd2, 32'h2, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lw2_value", rd, 32'h66554433);
    chk("lw2_be1", {28'h0, rec_be[0]}, 32'hC);
    chk("lw2_be2", {28'h0, rec_be[1]}, 32'h3);
`endif
    xact(1'b0, 3'd1, 32'h3, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lh3_value", rd, 32'h00005544);
`endif
    xact(1'b1, 3'd2, 32'h3, 32'hAABBCCDD, rd);
    xact(1'b0, 3'd2, 32'h0, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lw0_after_sw", rd, 32'hDD332211);
`endif
    xact(1'b0, 3'd2, 32'h4, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lw4_after_sw", rd, 32'h88AABBCC);
`endif
    xact(1'b0, 3'd2, 32'h7E, 32'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("wrap_addr1", rec_addr[0], 32'd31);
    chk("wrap_addr2", rec_addr[1], 32'd0);
`endif
    xact(1'b0, 3'd7, 32'h0, 32'h0, rd);
    xact(1'b1, 3'd3, 32'h8, 32'h12345678, rd);

    // Reset during the second cycle of a split store at byte 0x21.
    v = $urandom;
    req_valid = 1'b1; req_we = 1'b1; req_type = 3'd2; req_addr = 32'h21; req_wdata = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_wr_en", {31'h0, mem_wr_en}, 32'h0);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", {31'h0, req_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_no_rsp", {31'h0, rsp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    $display("xact reset-during-split-store addr=0x21 wdata=0x%08h", v);
    if (!is_err(1'b1, 3'd2, 32'h21))
      for (int i = 0; i < 3; i++) mref[32'h21 + i] = v[i*8 +: 8];
    xact(1'b0, 3'd2, 32'h20, 32'h0, rd);
    xact(1'b0, 3'd2, 32'h24, 32'h0, rd);

    // Randomized traffic against the byte model.
    for (int t = 0; t < 300; t++) begin
      logic [2:0] ty;
      ty = 3'($urandom_range(0, 7));
      xact(1'($urandom_range(0, 1)), ty, $urandom, $urandom, rd);
    end

    for (int w = 0; w < NW; w++)
      chk("final_mem_word", tmem[w], {mref[4*w+3], mref[4*w+2], mref[4*w+1], mref[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
